// File: rtl/rvv_vd_collector.sv
// Collects per-lane ALU result slices into one VLEN-bit destination image and hands it to VRF writeback.
// Optional RVV_COLLECT_MASK_EN: merge onto vd_old under an element mask (mask-undisturbed).
module rvv_vd_collector #(
  parameter int VLEN       = 128,
  parameter int LANE_WIDTH = 3,
  parameter int NB_LANES   = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      vsew,
  input  logic [255:0]    lane_data,
  input  logic [39:0]     lane_idx,
  input  logic [3:0]      lane_valid,
  input  logic            alu_done,
  output logic            busy,
  output logic            vd_valid,
  input  logic            vd_ready,
  output logic [VLEN-1:0] vd_out,
  output logic            err
`ifdef RVV_COLLECT_MASK_EN
  ,
  input  logic [VLEN/8-1:0] vmask,
  input  logic [VLEN-1:0]   vd_old
`endif
);

  localparam int NL = 1 << NB_LANES;
  localparam int CW = $clog2(VLEN/8) + 1;

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  state_t          r_state, w_state_nxt;
  logic [VLEN-1:0] r_acc, w_acc_nxt, w_mask;
  logic [CW-1:0]   r_cnt, w_cnt_nxt, w_n;
  logic [1:0]      r_sew, w_sew_in;
  logic            r_err, w_oor;
  logic [2:0]      w_lc3, w_lc, w_pop;
  logic [6:0]      w_c;
  logic [63:0]     w_cmask;
  logic [9:0]      w_idx;
  logic            w_wr;
  logic            w_unused;
`ifdef RVV_COLLECT_MASK_EN
  logic [VLEN/8-1:0] w_mvec;
`endif

  assign w_unused = ^{lane_data, lane_idx, lane_valid};

  assign w_sew_in = vsew[2] ? 2'd3 : vsew[1:0];
  assign w_lc3    = {1'b0, r_sew} + 3'd3;
  assign w_lc     = (w_lc3 < 3'(LANE_WIDTH)) ? w_lc3 : 3'(LANE_WIDTH);
  assign w_c      = 7'd1 << w_lc;
  assign w_n      = CW'(VLEN >> w_lc);
  // A 64-bit chunk shifts the 1 out entirely, so the subtraction yields all ones.
  assign w_cmask  = (64'd1 << w_c) - 64'd1;

  // Ascending lane order makes the higher lane win on overlap.
  always_comb begin
    w_acc_nxt = r_acc;
    w_pop     = '0;
    w_oor     = 1'b0;
    w_idx     = '0;
    w_mask    = '0;
    w_wr      = 1'b0;
`ifdef RVV_COLLECT_MASK_EN
    w_mvec    = '0;
`endif
    for (int i = 0; i < NL; i++) begin
      w_idx = lane_idx[10*i +: 10];
      if (lane_valid[i]) begin
        w_pop = w_pop + 3'd1;
        if (({1'b0, w_idx} + 11'(w_c)) <= 11'(VLEN)) begin
`ifdef RVV_COLLECT_MASK_EN
          w_mvec = vmask >> (w_idx >> ({1'b0, r_sew} + 3'd3));
          w_wr   = w_mvec[0];
`else
          w_wr   = 1'b1;
`endif
          if (w_wr) begin
            w_mask    = VLEN'(w_cmask) << w_idx;
            w_acc_nxt = (w_acc_nxt & ~w_mask) |
                        ((VLEN'(lane_data[64*i +: 64]) << w_idx) & w_mask);
          end
        end else begin
          w_oor = 1'b1;
        end
      end
    end
  end

  assign w_cnt_nxt = r_cnt + CW'(w_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = COLLECT;
      COLLECT: if ((w_cnt_nxt >= w_n) || alu_done) w_state_nxt = DONE;
      DONE:    if (vd_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_err <= 1'b0;
      r_sew <= '0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_sew <= w_sew_in;
          r_cnt <= '0;
          r_err <= 1'b0;
`ifdef RVV_COLLECT_MASK_EN
          r_acc <= vd_old;
`else
          r_acc <= '0;
`endif
        end
        COLLECT: begin
          r_acc <= w_acc_nxt;
          r_cnt <= w_cnt_nxt;
          if (w_oor) r_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy     = (r_state == COLLECT);
  assign vd_valid = (r_state == DONE);
  assign vd_out   = r_acc;
  assign err      = r_err;

endmodule

// File: tb/tb_rvv_vd_collector.sv
// Bench for rvv_vd_collector: directed scenarios plus a random cycle stream against a bit-level reference model.
module tb_rvv_vd_collector;
  localparam int VLEN = 128;
  localparam int LW   = 3;
  localparam int NBL  = 1;
  localparam int NL   = 1 << NBL;
  localparam logic [VLEN-1:0] EXP1 = 128'h0f0e0d0c0b0a09080706050403020100;

  logic            clk = 0;
  logic            reset = 1;
  logic            start = 0;
  logic [2:0]      vsew = 0;
  logic [255:0]    lane_data = '0;
  logic [39:0]     lane_idx = '0;
  logic [3:0]      lane_valid = '0;
  logic            alu_done = 0;
  logic            busy, vd_valid, err;
  logic            vd_ready = 0;
  logic [VLEN-1:0] vd_out;
`ifdef RVV_COLLECT_MASK_EN
  logic [VLEN/8-1:0] vmask = '1;
  logic [VLEN-1:0]   vd_old = '0;
`endif

  rvv_vd_collector #(.VLEN(VLEN), .LANE_WIDTH(LW), .NB_LANES(NBL)) dut (
    .clk(clk), .reset(reset), .start(start), .vsew(vsew),
    .lane_data(lane_data), .lane_idx(lane_idx), .lane_valid(lane_valid),
    .alu_done(alu_done), .busy(busy), .vd_valid(vd_valid), .vd_ready(vd_ready),
    .vd_out(vd_out), .err(err)
`ifdef RVV_COLLECT_MASK_EN
    , .vmask(vmask), .vd_old(vd_old)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [VLEN-1:0] got, input logic [VLEN-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: 0 idle, 1 collecting, 2 holding result.
  logic [VLEN-1:0] m_acc = '0;
  int m_st = 0, m_cnt = 0, m_sew = 0;
  bit m_err = 0;

  task automatic model_reset();
    m_acc = '0; m_st = 0; m_cnt = 0; m_sew = 0; m_err = 0;
  endtask

  task automatic cyc();
    int lc, c, idx;
    bit wr;
    lc = (m_sew + 3 > LW) ? LW : m_sew + 3;
    c  = 1 << lc;
    case (m_st)
      0: if (start) begin
        m_sew = (vsew > 3) ? 3 : int'(vsew);
`ifdef RVV_COLLECT_MASK_EN
        m_acc = vd_old;
`else
        m_acc = '0;
`endif
        m_cnt = 0; m_err = 0; m_st = 1;
      end
      1: begin
        for (int i = 0; i < NL; i++) begin
          if (lane_valid[i]) begin
            m_cnt++;
            idx = int'(lane_idx[10*i +: 10]);
            if (idx + c <= VLEN) begin
              wr = 1;
`ifdef RVV_COLLECT_MASK_EN
              wr = vmask[idx >> (m_sew + 3)];
`endif
              if (wr) for (int b = 0; b < c; b++) m_acc[idx+b] = lane_data[64*i+b];
            end else m_err = 1;
          end
        end
        if (m_cnt >= VLEN / c || alu_done) m_st = 2;
      end
      default: if (vd_ready) m_st = 0;
    endcase
    @(posedge clk); #1;
    chk("busy", busy, m_st == 1);
    chk("vd_valid", vd_valid, m_st == 2);
    chk("err", err, m_err);
    if (m_st != 1) chk("vd_out", vd_out, m_acc);
  endtask

  task automatic async_reset();
    #2 reset = 1;
    #1;
    model_reset();
    chk("rst_busy", busy, 0);
    chk("rst_vd_valid", vd_valid, 0);
    chk("rst_vd_out", vd_out, 0);
    chk("rst_err", err, 0);
    @(posedge clk); #1 reset = 0;
  endtask

  task automatic s1_start(input int sew);
    vsew = 3'(sew); start = 1; lane_valid = '0;
    cyc();
    start = 0;
  endtask

  task automatic s1_feed(input int k);
    logic [63:0] d0, d1;
    logic [1:0]  hi;
    d0 = {$urandom(), $urandom()}; d0[7:0] = 8'(2*k);
    d1 = {$urandom(), $urandom()}; d1[7:0] = 8'(2*k + 1);
    hi = 2'($urandom_range(0, 3));
    lane_data  = {$urandom(), $urandom(), $urandom(), $urandom(), d1, d0};
    lane_idx   = {10'($urandom()), 10'($urandom()), 10'(16*k + 8), 10'(16*k)};
    lane_valid = {hi, 2'b11};
    cyc();
    lane_valid = '0;
  endtask

  task automatic run_s1(input int sew);
    s1_start(sew);
    for (int k = 0; k < 8; k++) s1_feed(k);
  endtask

  initial begin
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_vd_valid", vd_valid, 0);
    chk("reset_vd_out", vd_out, 0);
    chk("reset_err", err, 0);
    @(posedge clk); #1 reset = 0;

    // Full 8-bit collect, then 32-bit elements with the same chunking.
    vd_ready = 1;
    run_s1(0);
    chk("s1_vd_out", vd_out, EXP1);
    cyc();
    run_s1(2);
    chk("s2_vd_out", vd_out, EXP1);
    cyc();

    // Backpressure with an ignored start pulse.
    vd_ready = 0;
    run_s1(0);
    for (int j = 0; j < 5; j++) begin
      start = (j == 2); vsew = 3'd1;
      cyc();
    end
    start = 0;
    chk("bp_vd_out", vd_out, EXP1);
    vd_ready = 1;
    cyc();
    chk("bp_drop", vd_valid, 0);

    // Early done with one out-of-range slice.
    s1_start(0);
    lane_data  = '0; lane_data[7:0] = 8'hAA; lane_data[71:64] = 8'h55;
    lane_idx   = {20'd0, 10'd125, 10'd0};
    lane_valid = 4'b0011; alu_done = 1;
    cyc();
    lane_valid = '0; alu_done = 0;
    chk("ed_vd_out", vd_out, 128'hAA);
    chk("ed_err", err, 1);
    cyc();

    // Reset in the middle of a collection, then a clean run.
    s1_start(0);
    for (int k = 0; k < 3; k++) s1_feed(k);
    async_reset();
    run_s1(0);
    chk("post_rst_vd_out", vd_out, EXP1);
    cyc();

`ifdef RVV_COLLECT_MASK_EN
    vd_old = '1; vmask = 16'h5555;
    run_s1(0);
    chk("mask_vd_out", vd_out, 128'hff0eff0cff0aff08ff06ff04ff02ff00);
    cyc();
`endif

    // Random cycle stream.
    for (int t = 0; t < 2000; t++) begin
      int sel;
      start     = ($urandom_range(0, 5) == 0);
      vsew      = 3'($urandom());
      alu_done  = ($urandom_range(0, 19) == 0);
      vd_ready  = ($urandom_range(0, 1) == 1);
      lane_data = {$urandom(), $urandom(), $urandom(), $urandom(),
                   $urandom(), $urandom(), $urandom(), $urandom()};
      lane_valid = ($urandom_range(0, 9) < 3) ? 4'd0 : 4'($urandom());
      for (int i = 0; i < 4; i++) begin
        sel = $urandom_range(0, 9);
        if (sel < 6)      lane_idx[10*i +: 10] = 10'($urandom_range(0, VLEN/8 - 1) * 8);
        else if (sel < 9) lane_idx[10*i +: 10] = 10'($urandom_range(VLEN - 13, VLEN + 2));
        else              lane_idx[10*i +: 10] = 10'($urandom());
      end
`ifdef RVV_COLLECT_MASK_EN
      vmask  = 16'($urandom());
      vd_old = {$urandom(), $urandom(), $urandom(), $urandom()};
`endif
      if ($urandom_range(0, 299) == 0) async_reset();
      else cyc();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
